// File: rtl/sc_game_status.sv
// Game-status register stage behind the Frogger principal FSM.
// It tracks lives, level and filled houses, and holds the sticky end-of-game flags.
module sc_game_status #(
    parameter int LIVES_INIT = 3,
    parameter int LEVEL_MAX  = 3,
    parameter int HOUSES_W   = 8
) (
    input  logic                SC_GAMESTATUS_CLOCK_50,
    input  logic                SC_GAMESTATUS_RESET_InHigh,
    input  logic                SC_GAMESTATUS_LIVEOUT,
    input  logic                SC_GAMESTATUS_LEVELOUT,
    input  logic [2:0]          SC_GAMESTATUS_RESETLEVEL,
    input  logic [3:0]          SC_GAMESTATUS_NEXTLEVEL,
    input  logic [HOUSES_W-1:0] SC_GAMESTATUS_LEVELOR,
    output logic [3:0]          SC_GAMESTATUS_LIVECOUNT,
    output logic [3:0]          SC_GAMESTATUS_LEVELCOUNT,
    output logic [HOUSES_W-1:0] SC_GAMESTATUS_HOUSES,
    output logic                SC_GAMESTATUS_LIFELOST,
    output logic                SC_GAMESTATUS_LEVELUP,
    output logic                SC_GAMESTATUS_GAMEOVER,
    output logic                SC_GAMESTATUS_GAMEWIN
);

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_CLEAR,
        ST_LOSE,
        ST_WIN
    } state_t;

    state_t              state_q;
    logic                liveout_q;
    logic                levelout_q;
    logic [3:0]          lives_q;
    logic [3:0]          level_q;
    logic [HOUSES_W-1:0] houses_q;
    logic                lifelost_q;
    logic                levelup_q;
    logic                gameover_q;
    logic                gamewin_q;

    logic                life_ev;
    logic                level_ev;
    logic                lose_cmd;
    logic                win_cmd;
    logic                clear_cmd;
    logic                lives_can_dec;
    logic                level_can_inc;

    // LIVEOUT also rises after a house hit, but then RESETLEVEL is non-zero,
    // so only a death produces a life-loss event.
    always_comb begin
        life_ev       = SC_GAMESTATUS_LIVEOUT & ~liveout_q & (SC_GAMESTATUS_RESETLEVEL == 3'b000);
        level_ev      = SC_GAMESTATUS_LEVELOUT & ~levelout_q;
        lose_cmd      = (SC_GAMESTATUS_RESETLEVEL == 3'b010);
        win_cmd       = (SC_GAMESTATUS_NEXTLEVEL == 4'b0011);
        clear_cmd     = (SC_GAMESTATUS_NEXTLEVEL == 4'b0010);
        lives_can_dec = (lives_q != 4'd0);
        level_can_inc = (level_q < 4'(LEVEL_MAX));
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge SC_GAMESTATUS_CLOCK_50) begin
        if (SC_GAMESTATUS_RESET_InHigh) begin
            state_q    <= ST_PLAY;
            liveout_q  <= 1'b0;
            levelout_q <= 1'b0;
            lives_q    <= 4'(LIVES_INIT);
            level_q    <= 4'd0;
            houses_q   <= '0;
            lifelost_q <= 1'b0;
            levelup_q  <= 1'b0;
            gameover_q <= 1'b0;
            gamewin_q  <= 1'b0;
        end else begin
            liveout_q  <= SC_GAMESTATUS_LIVEOUT;
            levelout_q <= SC_GAMESTATUS_LEVELOUT;
            lifelost_q <= 1'b0;
            levelup_q  <= 1'b0;

            case (state_q)
                ST_PLAY, ST_CLEAR: begin
                    if (lose_cmd) begin
                        state_q    <= ST_LOSE;
                        gameover_q <= 1'b1;
                    end else if (win_cmd) begin
                        state_q   <= ST_WIN;
                        gamewin_q <= 1'b1;
                    end else if (state_q == ST_CLEAR && clear_cmd) begin
                        houses_q <= '0;
                        state_q  <= ST_PLAY;
                    end else begin
                        if (life_ev && lives_can_dec) begin
                            lives_q    <= lives_q - 4'd1;
                            lifelost_q <= 1'b1;
                        end
                        if (level_ev) begin
                            if (level_can_inc) begin
                                level_q   <= level_q + 4'd1;
                                levelup_q <= 1'b1;
                            end
                            state_q <= ST_CLEAR;
                        end
                        // The house map is stale while a level change is pending.
                        if (state_q == ST_PLAY) begin
                            houses_q <= houses_q | SC_GAMESTATUS_LEVELOR;
                        end
                    end
                end
                default: begin
                    // ST_LOSE / ST_WIN: everything frozen until reset.
                end
            endcase
        end
    end

    assign SC_GAMESTATUS_LIVECOUNT  = lives_q;
    assign SC_GAMESTATUS_LEVELCOUNT = level_q;
    assign SC_GAMESTATUS_HOUSES     = houses_q;
    assign SC_GAMESTATUS_LIFELOST   = lifelost_q;
    assign SC_GAMESTATUS_LEVELUP    = levelup_q;
    assign SC_GAMESTATUS_GAMEOVER   = gameover_q;
    assign SC_GAMESTATUS_GAMEWIN    = gamewin_q;

endmodule

// File: tb/tb_sc_game_status.sv
// Directed bench for sc_game_status: lives, level, houses and end-of-game flags
// against hand-computed values, sampled 1 ns after each rising edge.
module tb_sc_game_status;

    logic       clk;
    logic       rst;
    logic       liveout;
    logic       levelout;
    logic [2:0] resetlevel;
    logic [3:0] nextlevel;
    logic [7:0] levelor;
    logic [3:0] livecount;
    logic [3:0] levelcount;
    logic [7:0] houses;
    logic       lifelost;
    logic       levelup;
    logic       gameover;
    logic       gamewin;

    int n_total = 0;
    int n_bad   = 0;

    sc_game_status #(
        .LIVES_INIT(3),
        .LEVEL_MAX (3),
        .HOUSES_W  (8)
    ) dut (
        .SC_GAMESTATUS_CLOCK_50    (clk),
        .SC_GAMESTATUS_RESET_InHigh(rst),
        .SC_GAMESTATUS_LIVEOUT     (liveout),
        .SC_GAMESTATUS_LEVELOUT    (levelout),
        .SC_GAMESTATUS_RESETLEVEL  (resetlevel),
        .SC_GAMESTATUS_NEXTLEVEL   (nextlevel),
        .SC_GAMESTATUS_LEVELOR     (levelor),
        .SC_GAMESTATUS_LIVECOUNT   (livecount),
        .SC_GAMESTATUS_LEVELCOUNT  (levelcount),
        .SC_GAMESTATUS_HOUSES      (houses),
        .SC_GAMESTATUS_LIFELOST    (lifelost),
        .SC_GAMESTATUS_LEVELUP     (levelup),
        .SC_GAMESTATUS_GAMEOVER    (gameover),
        .SC_GAMESTATUS_GAMEWIN     (gamewin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        liveout    = 1'b0;
        levelout   = 1'b0;
        resetlevel = 3'b000;
        nextlevel  = 4'b0000;
        levelor    = 8'h00;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_lives"},  32'(livecount),  32'd3);
        check({tag, "_level"},  32'(levelcount), 32'd0);
        check({tag, "_houses"}, 32'(houses),     32'h00);
        check({tag, "_flags"},  32'({lifelost, levelup, gameover, gamewin}), 32'h0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        check_reset_values("reset");

        rst = 1'b0;
        step();
        check("idle_lives", 32'(livecount), 32'd3);

        // Death: LIVEOUT high two cycles, second with RESETLEVEL=01.
        liveout = 1'b1;
        step();
        check("death_lives", 32'(livecount), 32'd2);
        check("death_pulse", 32'(lifelost),  32'd1);
        resetlevel = 3'b001;
        step();
        check("death2_lives", 32'(livecount), 32'd2);
        check("death2_pulse", 32'(lifelost),  32'd0);
        idle_inputs();
        step();

        // House hit: accumulate, and the LIVEOUT with RESETLEVEL=01 costs no life.
        levelor = 8'h04;
        step();
        check("house_map", 32'(houses), 32'h04);
        levelor    = 8'h00;
        liveout    = 1'b1;
        resetlevel = 3'b001;
        step();
        check("house_lives", 32'(livecount), 32'd2);
        check("house_pulse", 32'(lifelost),  32'd0);
        check("house_keep",  32'(houses),    32'h04);
        idle_inputs();
        step();

        // Level up, then house clear.
        levelor  = 8'hFF;
        levelout = 1'b1;
        step();
        check("lvl_count",  32'(levelcount), 32'd1);
        check("lvl_pulse",  32'(levelup),    32'd1);
        check("lvl_houses", 32'(houses),     32'hFF);
        idle_inputs();
        levelor = 8'h10;
        step();
        check("lvl_pulse_off",  32'(levelup), 32'd0);
        check("clear_ignores",  32'(houses),  32'hFF);
        levelor   = 8'h00;
        nextlevel = 4'b0010;
        step();
        check("clear_houses", 32'(houses), 32'h00);
        idle_inputs();
        levelor = 8'h01;
        step();
        check("play_again", 32'(houses), 32'h01);
        idle_inputs();

        // Three more level-ups from 1 saturate at LEVEL_MAX=3.
        for (int i = 0; i < 3; i++) begin
            levelout = 1'b1;
            step();
            levelout  = 1'b0;
            nextlevel = 4'b0010;
            step();
            nextlevel = 4'b0000;
            step();
        end
        check("lvl_sat", 32'(levelcount), 32'd3);
        check("lvl_sat_houses", 32'(houses), 32'h00);

        // Four deaths from 2 lives: 2->1->0->0->0.
        for (int i = 0; i < 4; i++) begin
            liveout = 1'b1;
            step();
            liveout = 1'b0;
            step();
        end
        check("lives_sat", 32'(livecount), 32'd0);

        // Lose, then everything frozen.
        resetlevel = 3'b010;
        step();
        check("lose_flag", 32'(gameover), 32'd1);
        check("lose_win",  32'(gamewin),  32'd0);
        idle_inputs();
        levelor  = 8'hFF;
        levelout = 1'b1;
        step();
        check("lose_houses", 32'(houses),     32'h00);
        check("lose_level",  32'(levelcount), 32'd3);
        check("lose_sticky", 32'(gameover),   32'd1);
        check("lose_lvlup",  32'(levelup),    32'd0);
        idle_inputs();

        rst = 1'b1;
        step();
        check_reset_values("reset2");
        rst = 1'b0;

        // Win, then reset mid-ST_WIN.
        nextlevel = 4'b0011;
        step();
        check("win_flag",  32'(gamewin),  32'd1);
        check("win_over",  32'(gameover), 32'd0);
        idle_inputs();
        liveout = 1'b1;
        step();
        check("win_frozen", 32'(livecount), 32'd3);
        check("win_sticky", 32'(gamewin),   32'd1);
        idle_inputs();
        rst = 1'b1;
        nextlevel = 4'b0011;
        step();
        check_reset_values("reset3");
        idle_inputs();
        rst = 1'b0;
        step();

        // Lose and win in the same cycle: lose wins.
        resetlevel = 3'b010;
        nextlevel  = 4'b0011;
        step();
        check("both_over", 32'(gameover), 32'd1);
        check("both_win",  32'(gamewin),  32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
